// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared states, default sizes and circular first-one search for the multiplier scheduler
package mul_sched_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF = 4;
  localparam int TIMEOUT_DEF = 32;
  function automatic logic [2:0] rr_first(input logic [7:0] r, input logic [2:0] p, input int n);
    logic [2:0] idx;
    logic [2:0] j;
    idx = p;
    for (int k = 7; k >= 0; k--) begin
      j = 3'((int'(p) + k) % n);
      if (k < n && r[j]) idx = j;
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search with a pointer that moves past the loaded owner
module rr_pick import mul_sched_pkg::*; #(
  parameter int N = N_REQ_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ld,
  input  logic [2:0]   ld_idx,
  output logic [N-1:0] win_oh,
  output logic [2:0]   win_idx,
  output logic         any
);
  logic [2:0] ptr_q, ptr_d;
  assign any = |req;
  always_comb begin
    win_idx = rr_first(8'(req), ptr_q, N);
    win_oh = any ? N'(1) << win_idx : '0;
    ptr_d = ld ? (ld_idx == 3'(N - 1) ? 3'd0 : ld_idx + 3'd1) : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? 3'd0 : ptr_d;
endmodule

// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin time-sharing of one sequential multiplier with done-edge detection and a watchdog
module mul_rr_sched import mul_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W = W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] mndo_in,
  input  logic [N_REQ*W-1:0] mdor_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_prod,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_st,
  output logic               mul_rst,
  output logic [W-1:0]       mul_mndo,
  output logic [W-1:0]       mul_mdor,
  input  logic               mul_done,
  input  logic [2*W-1:0]     mul_prod
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t st_q, st_d;
  logic [N_REQ-1:0] own_q, own_d, win_oh;
  logic [2:0] idx_q, idx_d, win_idx;
  logic [W-1:0] mndo_q, mndo_d, mdor_q, mdor_d;
  logic [2*W-1:0] res_q, res_d;
  logic [CW-1:0] wd_q, wd_d;
  logic err_q, err_d, done_q, any, rise;
  rr_pick #(.N(N_REQ)) u_pick (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ld(st_q == LAUNCH),
    .ld_idx(idx_q),
    .win_oh(win_oh),
    .win_idx(win_idx),
    .any(any)
  );
  assign rise = mul_done & ~done_q;
  always_comb begin
    st_d = st_q;
    own_d = own_q;
    idx_d = idx_q;
    mndo_d = mndo_q;
    mdor_d = mdor_q;
    res_d = res_q;
    err_d = err_q;
    wd_d = wd_q;
    case (st_q)
      IDLE: if (any) begin
        st_d = LAUNCH;
        own_d = win_oh;
        idx_d = win_idx;
        mndo_d = mndo_in[win_idx * W +: W];
        mdor_d = mdor_in[win_idx * W +: W];
      end
      LAUNCH: st_d = WAIT;
      WAIT: if (rise) begin
        res_d = mul_prod;
        st_d = RESP;
      end else if (wd_q == CW'(TIMEOUT_CYC - 1)) begin
        res_d = '0;
        err_d = 1'b1;
        st_d = RESP;
      end else begin
        wd_d = wd_q + CW'(1);
      end
      RESP: begin
        st_d = IDLE;
        err_d = 1'b0;
        wd_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      own_q <= '0;
      idx_q <= '0;
      mndo_q <= '0;
      mdor_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      wd_q <= '0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      own_q <= own_d;
      idx_q <= idx_d;
      mndo_q <= mndo_d;
      mdor_q <= mdor_d;
      res_q <= res_d;
      err_q <= err_d;
      wd_q <= wd_d;
      done_q <= mul_done;
    end
  end
  assign gnt = st_q == LAUNCH ? own_q : '0;
  assign rsp_valid = st_q == RESP ? own_q : '0;
  assign rsp_prod = st_q == RESP ? res_q : '0;
  assign rsp_err = st_q == RESP && err_q;
  assign mul_rst = st_q == RESP && err_q;
  assign busy = st_q != IDLE;
  assign mul_st = st_q == LAUNCH;
  assign mul_mndo = mndo_q;
  assign mul_mdor = mdor_q;
endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched: directed and random checks of the scheduler against a round-robin and multiplier reference model
module tb_mul_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] mndo_in = '0;
  logic [15:0] mdor_in = '0;
  logic [3:0] gnt, rsp_valid, mul_mndo, mul_mdor;
  logic [7:0] rsp_prod;
  logic [7:0] mul_prod = '0;
  logic rsp_err, busy, mul_st, mul_rst;
  logic mul_done = 1'b0;
  logic [3:0] a [4];
  logic [3:0] b [4];
  logic [3:0] ma = '0;
  logic [3:0] mb = '0;
  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  int mdl_delay = 10;
  int m_cnt = 0;
  bit mdl_hang = 0;
  bit mdl_stale = 0;
  bit m_busy = 0;
  time t_ref = 0;
  int gi;
  logic [7:0] ep;

  always #5 clk = ~clk;

  mul_rr_sched #(.N_REQ(4), .W(4), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst), .req(req), .mndo_in(mndo_in), .mdor_in(mdor_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .busy(busy), .mul_st(mul_st), .mul_rst(mul_rst), .mul_mndo(mul_mndo),
    .mul_mdor(mul_mdor), .mul_done(mul_done), .mul_prod(mul_prod)
  );

  always @(negedge clk) begin
    if (rst || mul_rst) begin
      m_busy = 0;
      mul_done = 1'b0;
    end else if (mul_st) begin
      m_busy = 1;
      m_cnt = 0;
      ma = mul_mndo;
      mb = mul_mdor;
      if (!mdl_stale) mul_done = 1'b0;
    end else if (m_busy && !mdl_hang) begin
      m_cnt++;
      if (m_cnt >= mdl_delay) begin
        mul_done = 1'b1;
        mul_prod = 8'(ma) * 8'(mb);
        m_busy = 0;
      end else if (mdl_stale && m_cnt >= 3) begin
        mul_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < 4; k++) begin
      mndo_in[k*4 +: 4] = a[k];
      mdor_in[k*4 +: 4] = b[k];
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int j = (p + k) % 4;
      if (r[2'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic await_gnt(output int idx, output time tg);
    idx = -1;
    tg = 0;
    for (int i = 0; i < 10 && idx < 0; i++) begin
      @(negedge clk);
      if (gnt != 0) begin
        tg = $time;
        for (int k = 0; k < 4; k++) if (gnt[k]) idx = k;
        chk("gnt_onehot", $countones(gnt), 1);
      end
    end
    chk("gnt_seen", idx >= 0, 1);
  endtask

  task automatic await_rsp(output int idx, output time tr);
    idx = -1;
    tr = 0;
    for (int i = 0; i < 60 && idx < 0; i++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        tr = $time;
        for (int k = 0; k < 4; k++) if (rsp_valid[k]) idx = k;
        chk("rsp_onehot", $countones(rsp_valid), 1);
      end
    end
    chk("rsp_seen", idx >= 0, 1);
  endtask

  task automatic begin_op(input int glat, output int g, output logic [7:0] p);
    int ew;
    time tg;
    ew = pick(req, ptr_m);
    await_gnt(g, tg);
    chk("gnt_idx", g, ew);
    p = '0;
    if (g < 0) return;
    if (glat > 0) chk("gnt_lat", 32'((tg - t_ref) / 10), glat);
    chk("mul_st", mul_st, 1);
    chk("busy", busy, 1);
    chk("mul_mndo", mul_mndo, a[g]);
    chk("mul_mdor", mul_mdor, b[g]);
    p = 8'(a[g]) * 8'(b[g]);
    ptr_m = (g + 1) % 4;
    t_ref = tg;
    a[g] = 4'($urandom);
    b[g] = 4'($urandom);
    drive_ops();
  endtask

  task automatic end_op(input int g, input logic [7:0] p, input bit keep);
    int ri;
    time tr;
    await_rsp(ri, tr);
    chk("rsp_idx", ri, g);
    chk("rsp_prod", rsp_prod, mdl_hang ? 8'd0 : p);
    chk("rsp_err", rsp_err, mdl_hang);
    chk("mul_rst", mul_rst, mdl_hang);
    chk("rsp_lat", 32'((tr - t_ref) / 10), mdl_hang ? 33 : mdl_delay + 1);
    t_ref = tr;
    if (!keep && g >= 0) req[g] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_prod"}, rsp_prod, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_st"}, mul_st, 0);
    chk({tag, "_mul_rst"}, mul_rst, 0);
    chk({tag, "_mul_mndo"}, mul_mndo, 0);
    chk({tag, "_mul_mdor"}, mul_mdor, 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      a[k] = '0;
      b[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");

    a[1] = 4'd7;
    b[1] = 4'd9;
    drive_ops();
    mdl_delay = 10;
    req = 4'b0010;
    rst = 1'b0;
    t_ref = $time;
    begin_op(1, gi, ep);
    end_op(gi, ep, 0);

    rst = 1'b1;
    ptr_m = 0;
    repeat (2) @(negedge clk);
    a = '{4'd3, 4'd15, 4'd0, 4'd8};
    b = '{4'd5, 4'd15, 4'd12, 4'd2};
    drive_ops();
    mdl_delay = 4;
    req = 4'hF;
    rst = 1'b0;
    t_ref = $time;
    begin_op(1, gi, ep);
    end_op(gi, ep, 1);
    for (int n = 0; n < 4; n++) begin
      begin_op(2, gi, ep);
      end_op(gi, ep, 0);
    end

    mdl_stale = 1;
    mdl_delay = 8;
    req = 4'b0010;
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);
    mdl_stale = 0;

    mdl_hang = 1;
    req = 4'b0100;
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);
    mdl_hang = 0;
    mdl_delay = 5;
    req = 4'b1000;
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);

    req = 4'b0010;
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);
    mdl_delay = 20;
    req = 4'b1100;
    begin_op(2, gi, ep);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midreset");
    rst = 1'b0;
    ptr_m = 0;
    mdl_delay = 6;
    t_ref = $time;
    begin_op(1, gi, ep);
    end_op(gi, ep, 0);
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);

    req = 4'b0010;
    begin_op(2, gi, ep);
    req[2] = 1'b1;
    req[3] = 1'b1;
    end_op(gi, ep, 0);
    req[2] = 1'b0;
    begin_op(2, gi, ep);
    req[2] = 1'b1;
    end_op(gi, ep, 0);
    begin_op(2, gi, ep);
    end_op(gi, ep, 0);

    for (int n = 0; n < 25; n++) begin
      if (req == 0) req = 4'($urandom_range(1, 15));
      mdl_delay = $urandom_range(1, 12);
      begin_op(2, gi, ep);
      req = req | 4'($urandom);
      end_op(gi, ep, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
